// File: rtl/noc_packet_sink.sv
// noc_packet_sink: mesh local-port receive endpoint with header check, body FIFO and stats (optional NOC_SINK_SEQ_CHECK_EN)
module noc_packet_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int COORD_W = 2,
  parameter int X_ID = 0,
  parameter int Y_ID = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic [COORD_W-1:0]    pkt_src_x,
  output logic [COORD_W-1:0]    pkt_src_y,
  output logic                  pkt_done,
`ifdef NOC_SINK_SEQ_CHECK_EN
  output logic [7:0]            err_seq,
`endif
  output logic [7:0]            receive_num,
  output logic [7:0]            err_misroute,
  output logic [7:0]            err_proto,
  output logic [7:0]            err_len
);
  localparam int C = COORD_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;
  state_t state, nxt;
  logic [7:0] len_r, cnt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic full, acc, push, pop, dest_ok, hdr, hdr_ok, tail_body, done;
  logic inc_proto, inc_mis, inc_len;
  logic [7:0] hdr_len;
  function automatic logic [7:0] sat(input logic [7:0] v, input logic en);
    return (en && v != 8'hff) ? v + 8'd1 : v;
  endfunction
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign receive_ready = (state == BODY) ? !full : 1'b1;
  assign out_valid = wr_ptr != rd_ptr;
  assign out_flit = mem[rd_ptr[AW-1:0]][DATA_WIDTH-1:0];
  assign out_last = mem[rd_ptr[AW-1:0]][DATA_WIDTH];
  assign pop = out_valid && out_ready;
  assign hdr_len = receive_flit[15:8];
  // decode the accepted flit into event strobes and the next FSM state
  always_comb begin
    acc = receive_valid && receive_ready;
    dest_ok = receive_flit[C-1:0] == X_ID[C-1:0] && receive_flit[2*C-1:C] == Y_ID[C-1:0];
    hdr = acc && receive_is_header;
    hdr_ok = hdr && dest_ok;
    push = acc && !receive_is_header && state == BODY;
    tail_body = push && receive_is_tail;
    done = (hdr_ok && receive_is_tail) || tail_body;
    inc_proto = acc && (receive_is_header ? state != IDLE : state == IDLE);
    inc_mis = hdr && !dest_ok;
    inc_len = (hdr_ok && receive_is_tail && hdr_len != 8'd0) || (tail_body && cnt + 8'd1 != len_r);
    nxt = !acc ? state : receive_is_tail ? IDLE : !receive_is_header ? state : dest_ok ? BODY : DROP;
  end
  // packet FSM, latched header fields, done pulse and statistics
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state <= IDLE;
      len_r <= '0;
      cnt <= '0;
      pkt_src_x <= '0;
      pkt_src_y <= '0;
      pkt_done <= 1'b0;
      receive_num <= '0;
      err_misroute <= '0;
      err_proto <= '0;
      err_len <= '0;
    end else begin
      state <= nxt;
      pkt_done <= done;
      receive_num <= receive_num + {7'd0, done};
      err_misroute <= sat(err_misroute, inc_mis);
      err_proto <= sat(err_proto, inc_proto);
      err_len <= sat(err_len, inc_len);
      if (hdr_ok) begin
        pkt_src_x <= receive_flit[3*C-1:2*C];
        pkt_src_y <= receive_flit[4*C-1:3*C];
        len_r <= hdr_len;
        cnt <= '0;
      end else if (push) cnt <= cnt + 8'd1;
    end
  end
  // body-flit FIFO; the extra pointer bit separates full from empty
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {receive_is_tail, receive_flit};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
`ifdef NOC_SINK_SEQ_CHECK_EN
  logic [7:0] seq_tab [2**(2*C)];
  logic [2*C-1:0] seq_idx;
  logic [7:0] seq_in;
  assign seq_idx = receive_flit[4*C-1:2*C];
  assign seq_in = receive_flit[23:16];
  // per-source expected sequence numbers, checked on every accepted header
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      err_seq <= '0;
      for (int i = 0; i < 2**(2*C); i++) seq_tab[i] <= '0;
    end else if (hdr_ok) begin
      err_seq <= sat(err_seq, seq_in != seq_tab[seq_idx]);
      seq_tab[seq_idx] <= seq_in + 8'd1;
    end
  end
`endif
endmodule
